cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_resp_valid  input  1  instruction word returned, in request order, latency >= 1 cycle, no backpressure.
REQ-008 imem_resp_data  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 dec_valid  output  1  instruction available to decode.
REQ-012 dec_ready  input  1  decode consumes the instruction this cycle.
REQ-013 dec_instr  output  32  instruction word at queue head.
REQ-014 dec_pc  output  32  address of dec_instr.
REQ-015 dec_imm_data  output  25  dec_instr[31:7], immediate-extender data field.

Function
REQ-016 Fetch PC register pc_q SHALL drive imem_req_addr; pc_q[1:0] always 0.
REQ-017 Request handshake = imem_req_valid && imem_req_ready; on handshake pc_q SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 Outstanding counter out_cnt (0..2) SHALL increment on request handshake and decrement on an accepted (non-dropped) response; both in one cycle leave it unchanged.
REQ-019 Instruction queue SHALL hold 2 entries of {instr, pc}; push on non-dropped imem_resp_valid, pop on dec_valid && dec_ready.
REQ-020 PC tag per request SHALL be kept in order so each pushed entry carries the address it was fetched from.
REQ-021 imem_req_valid SHALL be 1 iff !rst && !redirect_valid && (out_cnt + q_count - pop_this_cycle) < 2; queue can never overflow.
REQ-022 Response-to-output latency: an entry pushed in cycle t SHALL be visible on dec_* in cycle t+1 (no combinational bypass).
REQ-023 dec_valid = (q_count > 0); dec_instr/dec_pc/dec_imm_data SHALL stay stable while dec_valid && !dec_ready.
REQ-024 Simultaneous push and pop SHALL keep q_count unchanged and preserve order.
REQ-025 Redirect: next cycle pc_q = {redirect_pc[31:2], 2'b00}, queue and PC-tag queue empty, drop_cnt = out_cnt minus any response arriving in the redirect cycle.
REQ-026 While drop_cnt > 0 each imem_resp_valid SHALL be discarded and decrement drop_cnt; no push, no out_cnt change.
REQ-027 Redirect coinciding with pop or push: flush wins; the popped instruction counts as consumed, the pushed one is discarded.
REQ-028 Back-to-back redirects: the latest redirect_pc wins; drop_cnt accumulates correctly.
REQ-029 With 1-cycle memory, imem_req_ready=1, dec_ready=1: sustained one instruction per cycle.

Reset
REQ-030 While rst=1: pc_q=RESET_PC, q_count=0, out_cnt=0, drop_cnt=0, dec_valid=0, imem_req_valid=0.
REQ-031 Reset mid-operation SHALL discard all queued and outstanding state; the instruction memory shares rst and returns no stale responses afterwards.
REQ-032 First request SHALL issue in the first cycle with rst=0, at RESET_PC.

Verification
REQ-033 Reset release, 1-cycle memory, dec_ready=1 -> req addrs 0,4,8,...; dec_valid first high 2 cycles after reset release, then every cycle with dec_pc 0,4,8.
REQ-034 dec_ready=0 for 5 cycles -> at most 2 queued plus 0 outstanding; imem_req_valid low; dec_instr at pc 0 held stable; resume order 0,4,8 without loss.
REQ-035 3-cycle memory latency, 2 requests in flight, redirect_pc=32'h0000_0103 -> both stale responses dropped; next req addr 32'h0000_0100; dec_pc next = 0x100.
REQ-036 Redirect in same cycle as pop of pc 8 and push of pc 12 -> pc 12 never appears on dec_*; next dec_pc = redirect target.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> req addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 Assert rst mid-stream with queue full -> next cycle dec_valid=0, imem_req_valid=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_fetch.sv
// Instruction fetch front end: issues word-aligned fetches, tags each in-flight
// request with its PC, and buffers returned words in a 2-entry decode queue.
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [24:0] dec_imm_data
);

  logic [31:0] pc_q;
  logic [1:0]  out_cnt;
  logic [1:0]  q_count;
  logic [2:0]  drop_cnt;
  logic [31:0] tag_q   [2];
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];

  logic       req_fire;
  logic       pop;
  logic       resp_drop;
  logic       resp_acc;
  logic [2:0] in_flight;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign pop       = dec_valid && dec_ready;
  assign resp_drop = imem_resp_valid && (drop_cnt != 3'd0);
  assign resp_acc  = imem_resp_valid && (drop_cnt == 3'd0);

  // Every issued request must already own a queue slot, so the queue never overflows.
  assign in_flight      = {1'b0, out_cnt} + {1'b0, q_count} - {2'b00, pop};
  assign imem_req_valid = !rst && !redirect_valid && (in_flight < 3'd2);
  assign imem_req_addr  = pc_q;

  assign dec_valid    = !rst && (q_count != 2'd0);
  assign dec_instr    = q_instr[0];
  assign dec_pc       = q_pc[0];
  assign dec_imm_data = q_instr[0][31:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC & 32'hFFFF_FFFC;
      out_cnt  <= 2'd0;
      q_count  <= 2'd0;
      drop_cnt <= 3'd0;
    end else if (redirect_valid) begin
      // Responses still owed for flushed requests; one arriving now is already accounted for.
      pc_q     <= redirect_pc & 32'hFFFF_FFFC;
      out_cnt  <= 2'd0;
      q_count  <= 2'd0;
      drop_cnt <= drop_cnt + {1'b0, out_cnt} - {2'b00, imem_resp_valid};
    end else begin
      if (req_fire)
        pc_q <= pc_q + 32'd4;
      out_cnt <= out_cnt + {1'b0, req_fire} - {1'b0, resp_acc};
      q_count <= q_count + {1'b0, resp_acc} - {1'b0, pop};
      if (resp_drop)
        drop_cnt <= drop_cnt - 3'd1;
    end
  end

  // Payload storage; occupancy counters above decide which entries are meaningful.
  always_ff @(posedge clk) begin
    case ({req_fire, resp_acc})
      2'b10: tag_q[out_cnt[0]] <= pc_q;
      2'b01: tag_q[0] <= tag_q[1];
      2'b11: begin
        if (out_cnt == 2'd1) begin
          tag_q[0] <= pc_q;
        end else begin
          tag_q[0] <= tag_q[1];
          tag_q[1] <= pc_q;
        end
      end
      default: ;
    endcase

    case ({resp_acc, pop})
      2'b10: begin
        q_instr[q_count[0]] <= imem_resp_data;
        q_pc[q_count[0]]    <= tag_q[0];
      end
      2'b01: begin
        q_instr[0] <= q_instr[1];
        q_pc[0]    <= q_pc[1];
      end
      2'b11: begin
        if (q_count == 2'd1) begin
          q_instr[0] <= imem_resp_data;
          q_pc[0]    <= tag_q[0];
        end else begin
          q_instr[0] <= q_instr[1];
          q_pc[0]    <= q_pc[1];
          q_instr[1] <= imem_resp_data;
          q_pc[1]    <= tag_q[0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: a latency-programmable memory model feeds the
// DUT, directed scenarios push expected PCs, a monitor pops and compares on each pop.
module tb_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;
  logic [24:0] dec_imm_data;

  logic        req2_valid, req2_ready, resp2_valid, redirect2_valid;
  logic [31:0] req2_addr, resp2_data, redirect2_pc, dec2_instr, dec2_pc;
  logic        dec2_valid, dec2_ready;
  logic [24:0] dec2_imm;

  localparam logic [31:0] RESP2_WORD = 32'hCAFE_0013;

  always #5 clk = ~clk;

  cpu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_imm_data(dec_imm_data)
  );

  cpu_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req2_valid), .imem_req_ready(req2_ready), .imem_req_addr(req2_addr),
    .imem_resp_valid(resp2_valid), .imem_resp_data(resp2_data),
    .redirect_valid(redirect2_valid), .redirect_pc(redirect2_pc),
    .dec_valid(dec2_valid), .dec_ready(dec2_ready), .dec_instr(dec2_instr),
    .dec_pc(dec2_pc), .dec_imm_data(dec2_imm)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] req2_log[$];
  logic [31:0] exp_pc[$];
  int          lat = 1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        r2_pend = 1'b0;
  logic [31:0] mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp, input bit second);
    logic [31:0] v;
    int          n;
    n = second ? req2_log.size() : req_log.size();
    if (idx >= n) begin
      checks++;
      failures++;
      $display("FAIL %s actual=missing required=%h", name, exp);
    end else begin
      v = second ? req2_log[idx] : req_log[idx];
      chk(name, v, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory response drivers (in order, fixed latency, no backpressure)
  always @(negedge clk) begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    resp2_valid = r2_pend;
    resp2_data  = RESP2_WORD;
  end

  // Monitor: samples one time unit before the rising edge
  always @(negedge clk) begin
    #4;
    if (rst) begin
      mq.delete();
      req2_log.delete();
      r2_pend = 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_req_addr, due: cyc + lat});
        req_log.push_back(imem_req_addr);
      end
      if (dec_valid && dec_ready) begin
        if (exp_pc.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual_pc=%h required=none", dec_pc);
        end else begin
          mon_e = exp_pc.pop_front();
          chk("sb_pc", dec_pc, mon_e);
          chk("sb_instr", dec_instr, mem_word(mon_e));
          chk("sb_imm", {7'b0, dec_imm_data}, mem_word(mon_e) >> 7);
        end
      end
      r2_pend = req2_valid && req2_ready;
      if (r2_pend)
        req2_log.push_back(req2_addr);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("sb_drained", exp_pc.size(), 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_req2_addr", req2_addr, 32'hFFFF_FFF8);
    chk("rst_dec2_valid", dec2_valid, 0);
    exp_pc.delete();
    req_log.delete();
  endtask

  task automatic cyc_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    dec_ready = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    req2_ready = 1'b1; dec2_ready = 1'b1; redirect2_valid = 1'b0; redirect2_pc = 32'h0;

    // A: streaming at one per cycle, plus wrap check on the second instance
    do_reset();
    lat = 1;
    exp_pc = {32'h0, 32'h4, 32'h8, 32'hC};
    @(negedge clk); rst = 1'b0; dec_ready = 1'b1; #2;
    chk("a_first_req_valid", imem_req_valid, 1);
    chk("a_first_req_addr", imem_req_addr, 32'h0);
    chk("a_dec_valid_r0", dec_valid, 0);
    cyc_n(1);
    chk("a_dec_valid_r1", dec_valid, 0);
    for (int k = 2; k <= 5; k++) begin
      cyc_n(1);
      chk("a_dec_valid_stream", dec_valid, 1);
      chk("a_req_valid_stream", imem_req_valid, 1);
      if (k == 2) begin
        chk("f_dec2_pc", dec2_pc, 32'hFFFF_FFF8);
        chk("f_dec2_instr", dec2_instr, RESP2_WORD);
        chk("f_dec2_imm", {7'b0, dec2_imm}, RESP2_WORD >> 7);
      end
      if (k == 3) begin
        chk_log("f_req2_0", 0, 32'hFFFF_FFF8, 1'b1);
        chk_log("f_req2_1", 1, 32'hFFFF_FFFC, 1'b1);
        chk_log("f_req2_2", 2, 32'h0000_0000, 1'b1);
      end
    end
    for (int i = 0; i < 4; i++) chk_log("a_req_addr", i, 32'(4 * i), 1'b0);

    // B: decode stalls five cycles, queue fills, then drains in order
    do_reset();
    lat = 1;
    exp_pc = {32'h0, 32'h4, 32'h8, 32'hC};
    @(negedge clk); rst = 1'b0; #2;
    cyc_n(1);
    for (int k = 2; k <= 4; k++) begin
      cyc_n(1);
      chk("b_req_held", imem_req_valid, 0);
      chk("b_dec_valid", dec_valid, 1);
      chk("b_dec_pc_held", dec_pc, 32'h0);
      chk("b_dec_instr_held", dec_instr, mem_word(32'h0));
    end
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk); dec_ready = 1'b1; #2;
    end
    for (int i = 0; i < 4; i++) chk_log("b_req_addr", i, 32'(4 * i), 1'b0);

    // C: 3-cycle memory, redirect with two requests in flight, unaligned target
    do_reset();
    lat = 3;
    exp_pc = {32'h100, 32'h104};
    @(negedge clk); rst = 1'b0; dec_ready = 1'b1; #2;
    cyc_n(1);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #2;
    chk("c_req_during_redirect", imem_req_valid, 0);
    @(negedge clk); redirect_valid = 1'b0; #2;
    chk("c_req_valid_after", imem_req_valid, 1);
    chk("c_req_addr_after", imem_req_addr, 32'h100);
    chk("c_dec_valid_r3", dec_valid, 0);
    for (int k = 4; k <= 6; k++) begin
      cyc_n(1);
      chk("c_dec_valid_dropping", dec_valid, 0);
    end
    cyc_n(1);
    chk("c_dec_valid_r7", dec_valid, 1);
    chk("c_dec_pc_r7", dec_pc, 32'h100);
    cyc_n(1);
    chk_log("c_req0", 0, 32'h0, 1'b0);
    chk_log("c_req1", 1, 32'h4, 1'b0);
    chk_log("c_req2", 2, 32'h100, 1'b0);
    chk_log("c_req3", 3, 32'h104, 1'b0);

    // D: redirect coincides with pop of pc 8 and push of pc 12
    do_reset();
    lat = 1;
    exp_pc = {32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
    @(negedge clk); rst = 1'b0; dec_ready = 1'b1; #2;
    cyc_n(3);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
    chk("d_pop_pc_at_redirect", dec_pc, 32'h8);
    chk("d_push_at_redirect", imem_resp_valid, 1);
    @(negedge clk); redirect_valid = 1'b0; #2;
    chk("d_dec_valid_r5", dec_valid, 0);
    chk("d_req_addr_r5", imem_req_addr, 32'h200);
    cyc_n(1);
    chk("d_dec_valid_r6", dec_valid, 0);
    cyc_n(1);
    chk("d_dec_valid_r7", dec_valid, 1);
    chk("d_dec_pc_r7", dec_pc, 32'h200);
    cyc_n(1);

    // E: back-to-back redirects under 3-cycle memory
    do_reset();
    lat = 3;
    exp_pc = {32'h400};
    @(negedge clk); rst = 1'b0; dec_ready = 1'b1; #2;
    cyc_n(1);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h300; #2;
    @(negedge clk); redirect_pc = 32'h400; #2;
    @(negedge clk); redirect_valid = 1'b0; #2;
    chk("e_req_valid", imem_req_valid, 1);
    chk("e_req_addr", imem_req_addr, 32'h400);
    for (int k = 5; k <= 7; k++) begin
      cyc_n(1);
      chk("e_dec_valid_wait", dec_valid, 0);
    end
    cyc_n(1);
    chk("e_dec_valid_r8", dec_valid, 1);
    chk("e_dec_pc_r8", dec_pc, 32'h400);
    chk_log("e_req2", 2, 32'h400, 1'b0);
    chk_log("e_req3", 3, 32'h404, 1'b0);

    // G: reset asserted with the queue full
    do_reset();
    lat = 1;
    @(negedge clk); rst = 1'b0; #2;
    cyc_n(3);
    chk("g_dec_valid_full", dec_valid, 1);
    chk("g_req_valid_full", imem_req_valid, 0);
    @(negedge clk); rst = 1'b1; #2;
    chk("g_dec_valid_rst", dec_valid, 0);
    chk("g_req_valid_rst", imem_req_valid, 0);
    cyc_n(1);
    chk("g_dec_valid_rst2", dec_valid, 0);
    chk("g_req_valid_rst2", imem_req_valid, 0);
    @(negedge clk); rst = 1'b0; #2;
    chk("g_restart_valid", imem_req_valid, 1);
    chk("g_restart_addr", imem_req_addr, 32'h0);
    chk("g_dec_valid_r0", dec_valid, 0);
    cyc_n(1);
    chk("g_dec_valid_r1", dec_valid, 0);
    cyc_n(1);
    chk("g_dec_valid_r2", dec_valid, 1);
    chk("g_dec_pc_r2", dec_pc, 32'h0);

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
